// File: rtl/reg_file_mp.sv
// reg_file_mp: ID-stage register file with two combinational read ports,
// one write port, hard-wired zero register, per-register pending scoreboard
// and a sequential clear engine.
// Optional write-first forwarding is compiled in with `define REG_FILE_BYPASS_EN.

// One read port: zero-register and sweep/reset masking, optional forwarding.
module reg_file_mp_rd #(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic [2**ADDR_W-1:0][WIDTH-1:0] mem,
  input  logic [2**ADDR_W-1:0]            pend,
  input  logic [ADDR_W-1:0]               r_reg,
  input  logic                            force_zero,
  input  logic                            byp_en,
  input  logic                            byp_keep,
  input  logic [ADDR_W-1:0]               w_reg,
  input  logic [WIDTH-1:0]                w_data,
  output logic [WIDTH-1:0]                r_data,
  output logic                            r_pend
);
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  logic hit;
  assign hit = byp_en && (r_reg == w_reg);

  // Select array / forwarded value; a forwarded write retires the producer
  // unless a new producer is being issued to the same register this cycle.
  always_comb begin
    r_data = '0;
    r_pend = 1'b0;
    if (!force_zero && (r_reg != ZR)) begin
      if (hit) begin
        r_data = w_data;
        r_pend = byp_keep && pend[r_reg];
      end else begin
        r_data = mem[r_reg];
        r_pend = pend[r_reg];
      end
    end
  end
endmodule

module reg_file_mp #(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] r_reg1,
  input  logic [ADDR_W-1:0] r_reg2,
  output logic [WIDTH-1:0]  r_data1,
  output logic [WIDTH-1:0]  r_data2,
  output logic              r_pend1,
  output logic              r_pend2,
  input  logic [ADDR_W-1:0] w_reg,
  input  logic [WIDTH-1:0]  w_data,
  input  logic              RegWrite,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_reg,
  input  logic              clr_req,
  output logic              clr_busy
);
  localparam int NUM_REGS  = 2**ADDR_W;
  localparam int NUM_PORTS = 2;
  localparam logic [ADDR_W-1:0] ZR   = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS-1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                         state, state_nxt;
  logic [ADDR_W-1:0]              idx;
  logic [NUM_REGS-1:0][WIDTH-1:0] mem;
  logic [NUM_REGS-1:0]            pend, pend_nxt;
  logic                           idle, wr_en, byp_en, byp_keep, force_zero;

  assign idle       = (state == IDLE);
  assign wr_en      = RegWrite && idle && (w_reg != ZR);
  assign clr_busy   = (state == CLEAR);
  assign force_zero = !rst_n || !idle;

`ifdef REG_FILE_BYPASS_EN
  assign byp_en   = wr_en;
  assign byp_keep = iss_valid && (iss_reg == w_reg);
`else
  assign byp_en   = 1'b0;
  assign byp_keep = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: start sweep on request, finish after the last index
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req)     state_nxt = CLEAR;
      CLEAR:   if (idx == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep index: loaded with 0 on entry, wraps back to 0 after the last write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                idx <= '0;
    else if (idle && clr_req)  idx <= '0;
    else if (!idle)            idx <= idx + ADDR_W'(1);
  end

  // Storage: sweep zeroes one entry per cycle, otherwise WB write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mem <= '0;
    else if (!idle)  mem[idx] <= '0;
    else if (wr_en)  mem[w_reg] <= w_data;
  end

  // Scoreboard next value: write clears, issue sets (issue applied last so it wins)
  always_comb begin
    pend_nxt = pend;
    if (idle) begin
      if (clr_req) begin
        pend_nxt = '0;
      end else begin
        if (RegWrite)  pend_nxt[w_reg]   = 1'b0;
        if (iss_valid) pend_nxt[iss_reg] = 1'b1;
      end
    end
    pend_nxt[ZR] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

  logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_PORTS-1:0][WIDTH-1:0]  rd_data;
  logic [NUM_PORTS-1:0]             rd_pend;

  assign rd_addr = {r_reg2, r_reg1};
  assign r_data1 = rd_data[0];
  assign r_data2 = rd_data[1];
  assign r_pend1 = rd_pend[0];
  assign r_pend2 = rd_pend[1];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    reg_file_mp_rd #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rd (
      .mem        (mem),
      .pend       (pend),
      .r_reg      (rd_addr[p]),
      .force_zero (force_zero),
      .byp_en     (byp_en),
      .byp_keep   (byp_keep),
      .w_reg      (w_reg),
      .w_data     (w_data),
      .r_data     (rd_data[p]),
      .r_pend     (rd_pend[p])
    );
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (default or bypass build).
module tb_reg_file_mp;
  localparam int WIDTH  = 64;
  localparam int ADDR_W = 5;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] r_reg1, r_reg2, w_reg, iss_reg;
  logic [WIDTH-1:0]  r_data1, r_data2, w_data;
  logic              r_pend1, r_pend2, RegWrite, iss_valid, clr_req, clr_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .r_reg1(r_reg1), .r_reg2(r_reg2),
    .r_data1(r_data1), .r_data2(r_data2),
    .r_pend1(r_pend1), .r_pend2(r_pend2),
    .w_reg(w_reg), .w_data(w_data), .RegWrite(RegWrite),
    .iss_valid(iss_valid), .iss_reg(iss_reg),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    r_reg1 = '0; r_reg2 = '0; w_reg = '0; w_data = '0;
    RegWrite = 1'b0; iss_valid = 1'b0; iss_reg = '0; clr_req = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", clr_busy, 0);
    chk("rst_data1", r_data1, 0);
    chk("rst_pend1", r_pend1, 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      r_reg1 = ADDR_W'(i);
      r_reg2 = ADDR_W'(31 - i);
      #1;
      chk("init_data1", r_data1, 0);
      chk("init_data2", r_data2, 0);
      chk("init_pend", {r_pend2, r_pend1}, 0);
    end
    tick();

    // Write X5 while reading X5
    r_reg1 = 5; w_reg = 5; w_data = 64'hDEADBEEF_00000005; RegWrite = 1'b1;
    #1;
    chk("wr_x5_same", r_data1, BYP ? 64'hDEADBEEF_00000005 : 64'h0);
    tick();
    RegWrite = 1'b0; w_data = '0;
    #1;
    chk("wr_x5_next", r_data1, 64'hDEADBEEF_00000005);

    // XZR: writes discarded, never pending
    w_reg = 31; w_data = '1; RegWrite = 1'b1; r_reg1 = 31; r_reg2 = 31;
    #1;
    chk("xzr_same", r_data1, 0);
    tick();
    RegWrite = 1'b0;
    #1;
    chk("xzr_rd1", r_data1, 0);
    chk("xzr_rd2", r_data2, 0);
    iss_valid = 1'b1; iss_reg = 31;
    tick();
    iss_valid = 1'b0;
    #1;
    chk("xzr_pend", r_pend1, 0);

    // Scoreboard on X9 (port 1) and X12 (port 2)
    r_reg1 = 9; r_reg2 = 12; iss_valid = 1'b1; iss_reg = 9;
    #1;
    chk("iss9_before", r_pend1, 0);
    tick();                                   // edge t
    iss_reg = 12;
    #1;
    chk("iss9_t1", r_pend1, 1);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("iss12_p2", r_pend2, 1);
    tick();                                   // now cycle t+3
    w_reg = 9; w_data = 64'h99; RegWrite = 1'b1;
    #1;
    chk("wb9_pend_t3", r_pend1, BYP ? 64'h0 : 64'h1);
    chk("wb9_data_t3", r_data1, BYP ? 64'h99 : 64'h0);
    tick();
    RegWrite = 1'b0;
    #1;
    chk("wb9_pend_t4", r_pend1, 0);
    chk("wb9_data_t4", r_data1, 64'h99);
    chk("iss12_hold", r_pend2, 1);
    // Same-cycle issue and write: set wins
    iss_valid = 1'b1; iss_reg = 9; RegWrite = 1'b1; w_data = 64'hAA;
    tick();
    iss_valid = 1'b0; RegWrite = 1'b0;
    #1;
    chk("set_wins_pend", r_pend1, 1);
    chk("set_wins_data", r_data1, 64'hAA);

    // Fill X1..X4, reserve X7, then sweep
    for (int i = 1; i <= 4; i++) begin
      w_reg = ADDR_W'(i); w_data = 64'(i); RegWrite = 1'b1;
      tick();
    end
    RegWrite = 1'b0; iss_valid = 1'b1; iss_reg = 7;
    tick();
    iss_valid = 1'b0; r_reg1 = 1; r_reg2 = 7;
    #1;
    chk("pre_x1", r_data1, 1);
    chk("pre_p7", r_pend2, 1);
    clr_req = 1'b1;
    tick();                                   // edge t
    clr_req = 1'b0;
    chk("swp_busy0", clr_busy, 1);
    chk("swp_forced_d", r_data1, 0);
    chk("swp_forced_p", r_pend2, 0);
    w_reg = 2; w_data = 64'h7; RegWrite = 1'b1; iss_valid = 1'b1; iss_reg = 3;
    n = 0;
    while (clr_busy && n < 100) begin
      n++;
      tick();
    end
    RegWrite = 1'b0; iss_valid = 1'b0;
    chk("swp_cycles", 64'(n), 64'd32);
    for (int i = 1; i <= 4; i++) begin
      r_reg1 = ADDR_W'(i);
      #1;
      chk("post_swp_data", r_data1, 0);
    end
    for (int i = 0; i < 32; i++) begin
      r_reg2 = ADDR_W'(i);
      #1;
      chk("post_swp_pend", r_pend2, 0);
    end
    // First write after the sweep commits
    @(posedge clk); #1;
    w_reg = 2; w_data = 64'h7; RegWrite = 1'b1; r_reg1 = 2;
    tick();
    RegWrite = 1'b0;
    #1;
    chk("post_swp_wr", r_data1, 64'h7);

    // Reset in the middle of a sweep
    iss_valid = 1'b1; iss_reg = 4;
    tick();
    iss_valid = 1'b0; clr_req = 1'b1;
    tick();                                   // edge t
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_busy", clr_busy, 1);
    rst_n = 1'b0; r_reg1 = 2; r_reg2 = 4;
    #1;
    chk("mid_rst_busy", clr_busy, 0);
    chk("mid_rst_d1", r_data1, 0);
    chk("mid_rst_p2", r_pend2, 0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rel_x2", r_data1, 0);
    tick();
    chk("rel_busy", clr_busy, 0);
    w_reg = 3; w_data = 64'h33; RegWrite = 1'b1; r_reg2 = 3;
    tick();
    RegWrite = 1'b0;
    #1;
    chk("rel_wr_x3", r_data2, 64'h33);
    chk("rel_busy2", clr_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised successor to the ID-stage register file. It keeps two combinational read ports and one write port, and adds four things:
- a hard-wired zero register (XZR);
- optional write-to-read bypass;
- a per-register pending scoreboard for hazard detection;
- a sequential clear engine that zeroes the array on request without asserting reset.

It sits in the ID stage, between the decoder (read addresses, issue reservations) and the WB stage (write port).

## Interface
Parameters:
- WIDTH, 64, data width of each register.
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W.
- ZERO_REG, 31, index that always reads 0 (XZR).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- r_reg1  input  ADDR_W  read address, port 1.
- r_reg2  input  ADDR_W  read address, port 2.
- r_data1  output  WIDTH  read data, port 1.
- r_data2  output  WIDTH  read data, port 2.
- r_pend1  output  1  register r_reg1 has an outstanding producer.
- r_pend2  output  1  register r_reg2 has an outstanding producer.
- w_reg  input  ADDR_W  write address (WB).
- w_data  input  WIDTH  write data.
- RegWrite  input  1  write enable.
- iss_valid  input  1  an instruction issues with destination iss_reg.
- iss_reg  input  ADDR_W  destination being reserved.
- clr_req  input  1  start a clear sweep (single-cycle pulse or level).
- clr_busy  output  1  clear sweep in progress.

## Operation
- Storage: NUM_REGS x WIDTH flops. No file preload.
- Reads are combinational.
  - r_reg == ZERO_REG returns 0.
  - Otherwise returns the array content, or the bypass value (see Configuration).
- Writes commit on the rising edge when RegWrite=1 and FSM=IDLE. Writes to ZERO_REG are discarded.
- Scoreboard: pend[NUM_REGS-1:0].
  - iss_valid sets pend[iss_reg].
  - RegWrite clears pend[w_reg].
  - If both hit the same register in the same cycle, set wins (a newer producer now owns it).
  - pend[ZERO_REG] stays 0.
  - r_pendN = pend[r_regN].
- FSM has two states, IDLE and CLEAR.
  - IDLE -> CLEAR when clr_req=1. On that transition, pend is cleared entirely and the index counter is loaded with 0.
  - In CLEAR: each cycle writes 0 to array[idx], then idx increments.
  - CLEAR -> IDLE when idx == NUM_REGS-1 has been written.
  - In CLEAR, RegWrite, iss_valid and clr_req are ignored.
  - In CLEAR, r_data1/2 and r_pend1/2 are forced to 0.
- Reset (asynchronous):
  - array = 0, pend = 0, FSM = IDLE, idx = 0.
  - While rst_n=0: r_data1/2 = 0, r_pend1/2 = 0, clr_busy = 0.
- Reset mid-sweep aborts to IDLE with all state zeroed. No write is lost beyond those already discarded by reset.

## Timing
- Read latency: 0 cycles, combinational from r_reg.
- Write: visible to a read in the cycle after the edge; same cycle if bypass is compiled in.
- Scoreboard: iss_valid at edge t makes r_pend=1 from t+1.
- Clear sweep:
  - clr_req sampled high at edge t.
  - clr_busy=1 from t to t+NUM_REGS, i.e. NUM_REGS cycles.
  - Returns to IDLE after edge t+NUM_REGS.
  - The first accepted RegWrite commits at edge t+NUM_REGS+1.
- clr_busy is a registered output, a direct decode of FSM=CLEAR.

## Configuration
- REG_FILE_BYPASS_EN defined (write-first forwarding):
  - When RegWrite=1, FSM=IDLE, w_reg != ZERO_REG and r_regN == w_reg, then r_dataN = w_data in the same cycle.
  - In the same case, r_pendN = 0 unless iss_valid && iss_reg == w_reg in that cycle.
- REG_FILE_BYPASS_EN undefined:
  - r_dataN returns the pre-write array value until the edge.
  - r_pendN reflects the registered pend only.

## Test plan
- Reset, then read all 32 registers -> every r_data1/2 = 0; r_pend1/2 = 0; clr_busy = 0.
- Write X5 = 0xDEADBEEF_00000005 while reading X5 in the same cycle:
  - With bypass: r_data1 = 0xDEADBEEF_00000005 that cycle.
  - Without bypass: 0 that cycle, the new value the next cycle.
- Write X31 = 0xFFFF_FFFF_FFFF_FFFF, then read X31 -> 0. Issue to X31 -> r_pend stays 0.
- Issue X9 at t -> r_pend1 = 1 from t+1.
  - WB write X9 at t+3 -> r_pend1 = 0 from t+4 (from t+3 with bypass).
  - Issue X9 and write X9 in the same cycle -> pend remains 1.
- Write X1..X4 = 1..4, pulse clr_req at t:
  - clr_busy high for exactly 32 cycles.
  - RegWrite X2 = 7 during the sweep is discarded.
  - After the sweep, X1..X4 read 0 and all pend = 0.
- Start a sweep, deassert rst_n at sweep cycle 10 -> clr_busy = 0 immediately and all reads 0. After release, the FSM is IDLE and a write to X3 commits normally.
